// File: rtl/race_pkg.sv
// Shared encodings for the drag-race sequencer: FSM states, winner codes and
// the {seconds, ms} scoreboard time layout.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISHED  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  localparam int TIME_W = 22;
  localparam int MS_W   = 10;
  localparam int SEC_W  = 12;

  localparam logic [MS_W-1:0]  MS_LAST = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX = 12'd4095;

endpackage

// File: rtl/race_stopwatch.sv
// Per-player race stopwatch in {seconds, ms} form; advances one ms per tick while run is high.
// Output registered, visible one clk after the tick; clear dominates run; no backpressure.
module race_stopwatch
  import race_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              run,
  input  logic              tick_1khz,
  output logic [TIME_W-1:0] sw_time
);

  logic [SEC_W-1:0] sec;
  logic [MS_W-1:0]  ms;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sec <= '0;
      ms  <= '0;
    end else if (run && tick_1khz) begin
      if (ms == MS_LAST) begin
        ms <= '0;
        // seconds pin at full scale while ms keeps cycling
        if (sec != SEC_MAX) sec <= sec + 12'd1;
      end else begin
        ms <= ms + 10'd1;
      end
    end
  end

  assign sw_time = {sec, ms};

endmodule

// File: rtl/race_controller.sv
// Drag-race sequencer: start lights, stopwatches, finish/timeout arbitration; all outputs one clk after the sampling edge, no backpressure.
// Optional RACE_FALSE_START_EN: throttle during countdown marks that player DNF at the finish.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned FINISH_LINE_POS = 500,
  parameter int unsigned NUM_LIGHTS      = 5,
  parameter int unsigned LIGHT_STEP_MS   = 1000,
  parameter int unsigned RACE_TIMEOUT_S  = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1khz,
  input  logic              start_req,
  input  logic              restart_req,
  input  logic [31:0]       p1_position,
  input  logic [31:0]       p2_position,
  input  logic              p1_throttle,
  input  logic              p2_throttle,
  output logic [1:0]        state,
  output logic [2:0]        light_stage,
  output logic              p1_enable,
  output logic              p2_enable,
  output logic [TIME_W-1:0] p1_time,
  output logic [TIME_W-1:0] p2_time,
  output logic              p1_dnf,
  output logic              p2_dnf,
  output logic [1:0]        winner,
  output logic              end_game,
  output logic              clear_pulse
);

  localparam logic [31:0] FINISH_POS = 32'(FINISH_LINE_POS);
  localparam logic [31:0] TIMEOUT_MS = 32'(RACE_TIMEOUT_S * 1000);
  localparam logic [15:0] STEP_LAST  = 16'(LIGHT_STEP_MS - 1);
  localparam logic [2:0]  LIGHTS_ALL = 3'(NUM_LIGHTS);

  state_t      st;
  logic [15:0] step_cnt;
  logic [31:0] race_ms;
  logic        p1_done, p2_done;
  logic        p1_cross, p2_cross, fin1, fin2;
  logic        abort, launch, timeout;

  assign abort    = restart_req && (st != ST_IDLE);
  assign launch   = start_req && (st == ST_IDLE);
  assign p1_cross = p1_position >= FINISH_POS;
  assign p2_cross = p2_position >= FINISH_POS;
  assign fin1     = p1_done || p1_cross;
  assign fin2     = p2_done || p2_cross;
  assign timeout  = tick_1khz && (race_ms == TIMEOUT_MS - 32'd1);
  assign state    = st;

`ifdef RACE_FALSE_START_EN
  logic       p1_jump, p2_jump;
  logic [1:0] jump_winner;
  assign jump_winner = (fin1 && !p1_jump) ? WIN_P1 :
                       (fin2 && !p2_jump) ? WIN_P2 : WIN_NONE;
`else
  logic unused_throttle;
  assign unused_throttle = p1_throttle ^ p2_throttle;
`endif

  // A crossing edge freezes the stopwatch on that same edge, so run uses fin, not done.
  race_stopwatch u_sw_p1 (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort || launch),
    .run       ((st == ST_RACE) && !fin1),
    .tick_1khz (tick_1khz),
    .sw_time   (p1_time)
  );

  race_stopwatch u_sw_p2 (
    .clk       (clk),
    .reset     (reset),
    .clear     (abort || launch),
    .run       ((st == ST_RACE) && !fin2),
    .tick_1khz (tick_1khz),
    .sw_time   (p2_time)
  );

  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      st          <= ST_IDLE;
      light_stage <= '0;
      step_cnt    <= '0;
      race_ms     <= '0;
      p1_done     <= 1'b0;
      p2_done     <= 1'b0;
      p1_enable   <= 1'b0;
      p2_enable   <= 1'b0;
      p1_dnf      <= 1'b0;
      p2_dnf      <= 1'b0;
      winner      <= WIN_NONE;
      end_game    <= 1'b0;
      clear_pulse <= reset && abort;
`ifdef RACE_FALSE_START_EN
      p1_jump     <= 1'b0;
      p2_jump     <= 1'b0;
`endif
    end else begin
      clear_pulse <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (start_req) begin
            st          <= ST_COUNTDOWN;
            light_stage <= '0;
            step_cnt    <= '0;
          end
        end
        ST_COUNTDOWN: begin
`ifdef RACE_FALSE_START_EN
          p1_jump <= p1_jump || p1_throttle;
          p2_jump <= p2_jump || p2_throttle;
`endif
          if (tick_1khz) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt    <= '0;
              light_stage <= light_stage + 3'd1;
              if (light_stage + 3'd1 == LIGHTS_ALL) begin
                st        <= ST_RACE;
                race_ms   <= '0;
                p1_enable <= 1'b1;
                p2_enable <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end
        ST_RACE: begin
          if (tick_1khz) race_ms <= race_ms + 32'd1;
          p1_done <= fin1;
          p2_done <= fin2;
          if (!p1_done && !p2_done && (p1_cross || p2_cross))
            winner <= (p1_cross && p2_cross) ? WIN_TIE : (p1_cross ? WIN_P1 : WIN_P2);
          if ((fin1 && fin2) || timeout) begin
            st        <= ST_FINISHED;
            end_game  <= 1'b1;
            p1_enable <= 1'b0;
            p2_enable <= 1'b0;
            p1_dnf    <= !fin1;
            p2_dnf    <= !fin2;
`ifdef RACE_FALSE_START_EN
            // a jump-start overrides the physical result at the flag
            if (p1_jump || p2_jump) begin
              p1_dnf <= !fin1 || p1_jump;
              p2_dnf <= !fin2 || p2_jump;
              winner <= jump_winner;
            end
`endif
          end else begin
            p1_enable <= !fin1;
            p2_enable <= !fin2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: vector table, directed race scenarios, and a randomized
// run against a millisecond-level reference model.
module tb_race_controller;
  import race_pkg::*;

  localparam int L = 4;
  localparam int NL = 5;
  localparam int TO_S = 2;
  localparam int FIN = 500;
  localparam logic [31:0] FIN_POS = 32'd500;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1khz = 1'b0, start_req = 1'b0, restart_req = 1'b0;
  logic        p1_throttle = 1'b0, p2_throttle = 1'b0;
  logic [31:0] p1_position = '0, p2_position = '0;
  logic [1:0]  state;
  logic [2:0]  light_stage;
  logic        p1_enable, p2_enable, p1_dnf, p2_dnf, end_game, clear_pulse;
  logic [21:0] p1_time, p2_time;
  logic [1:0]  winner;
  logic [56:0] dut_vec;

  race_controller #(.FINISH_LINE_POS(FIN), .NUM_LIGHTS(NL), .LIGHT_STEP_MS(L), .RACE_TIMEOUT_S(TO_S)) dut (
    .clk(clk), .reset(reset), .tick_1khz(tick_1khz), .start_req(start_req), .restart_req(restart_req),
    .p1_position(p1_position), .p2_position(p2_position), .p1_throttle(p1_throttle), .p2_throttle(p2_throttle),
    .state(state), .light_stage(light_stage), .p1_enable(p1_enable), .p2_enable(p2_enable),
    .p1_time(p1_time), .p2_time(p2_time), .p1_dnf(p1_dnf), .p2_dnf(p2_dnf),
    .winner(winner), .end_game(end_game), .clear_pulse(clear_pulse)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, light_stage, p1_enable, p2_enable, p1_time, p2_time,
                    p1_dnf, p2_dnf, winner, end_game, clear_pulse};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start_req = 1'b0; restart_req = 1'b0; tick_1khz = 1'b0;
    p1_throttle = 1'b0; p2_throttle = 1'b0;
    p1_position = '0; p2_position = '0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic do_restart();
    restart_req = 1'b1;
    cyc();
    restart_req = 1'b0;
  endtask

  function automatic logic [21:0] tfmt(input int t);
    int s;
    s = t / 1000;
    if (s > 4095) s = 4095;
    return {s[11:0], 10'(t % 1000)};
  endfunction

  // From IDLE: start, then tick every cycle through all lights into RACE.
  task automatic run_countdown(input logic thr1);
    start_req = 1'b1;
    tick_1khz = 1'b0;
    cyc();
    start_req = 1'b0;
    chk("cd_enter", 64'(state), 64'(ST_COUNTDOWN));
    p1_throttle = thr1;
    tick_1khz = 1'b1;
    for (int k = 1; k <= NL * L; k++) begin
      cyc();
      chk("cd_light", 64'(light_stage), 64'(k / L));
      chk("cd_state", 64'(state), (k < NL * L) ? 64'(ST_COUNTDOWN) : 64'(ST_RACE));
    end
    p1_throttle = 1'b0;
    chk("race_enables", 64'({p1_enable, p2_enable}), 64'(2'b11));
    chk("race_times0", 64'({p1_time, p2_time}), 64'd0);
  endtask

  // Vector table for IDLE/COUNTDOWN request handling.
  typedef struct {
    logic       st;
    logic       rs;
    logic       tk;
    logic [1:0] e_state;
    logic [2:0] e_light;
    logic       e_clr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic t,
                              input logic [1:0] es, input logic [2:0] el, input logic ec);
    vec_t v;
    v.st = s; v.rs = r; v.tk = t; v.e_state = es; v.e_light = el; v.e_clr = ec;
    return v;
  endfunction

  // Reference model: whole-race quantities as plain integers.
  int m_phase, m_cd, m_race, m_t1, m_t2, m_win;
  bit m_done1, m_done2, m_dnf1, m_dnf2, m_en1, m_en2, m_end, m_clr;
`ifdef RACE_FALSE_START_EN
  bit m_j1, m_j2;
`endif

  task automatic model_clear();
    m_phase = 0; m_cd = 0; m_race = 0; m_t1 = 0; m_t2 = 0; m_win = 0;
    m_done1 = 0; m_done2 = 0; m_dnf1 = 0; m_dnf2 = 0;
    m_en1 = 0; m_en2 = 0; m_end = 0; m_clr = 0;
`ifdef RACE_FALSE_START_EN
    m_j1 = 0; m_j2 = 0;
`endif
  endtask

  task automatic model_step();
    bit c1, c2;
    if (!reset) begin
      model_clear();
      return;
    end
    m_clr = 0;
    if (restart_req && m_phase != 0) begin
      model_clear();
      m_clr = 1;
      return;
    end
    case (m_phase)
      0: if (start_req) begin model_clear(); m_phase = 1; end
      1: begin
`ifdef RACE_FALSE_START_EN
        m_j1 = m_j1 | p1_throttle;
        m_j2 = m_j2 | p2_throttle;
`endif
        if (tick_1khz) begin
          m_cd++;
          if (m_cd == NL * L) begin m_phase = 2; m_en1 = 1; m_en2 = 1; end
        end
      end
      2: begin
        c1 = !m_done1 && (p1_position >= FIN_POS);
        c2 = !m_done2 && (p2_position >= FIN_POS);
        if (tick_1khz) begin
          m_race++;
          if (!m_done1 && !c1) m_t1++;
          if (!m_done2 && !c2) m_t2++;
        end
        if (!m_done1 && !m_done2 && (c1 || c2)) m_win = (c1 && c2) ? 3 : (c1 ? 1 : 2);
        m_done1 = m_done1 | c1;
        m_done2 = m_done2 | c2;
        if ((m_done1 && m_done2) || m_race == TO_S * 1000) begin
          m_phase = 3; m_end = 1; m_en1 = 0; m_en2 = 0;
          m_dnf1 = !m_done1; m_dnf2 = !m_done2;
`ifdef RACE_FALSE_START_EN
          if (m_j1 || m_j2) begin
            m_dnf1 = m_dnf1 | m_j1;
            m_dnf2 = m_dnf2 | m_j2;
            m_win = (m_done1 && !m_j1) ? 1 : ((m_done2 && !m_j2) ? 2 : 0);
          end
`endif
        end else begin
          m_en1 = !m_done1;
          m_en2 = !m_done2;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [56:0] model_vec();
    logic [2:0] el;
    el = (m_phase == 0) ? 3'd0 : ((m_phase == 1) ? 3'(m_cd / L) : 3'(NL));
    return {2'(m_phase), el, m_en1, m_en2, tfmt(m_t1), tfmt(m_t2),
            m_dnf1, m_dnf2, 2'(m_win), m_end, m_clr};
  endfunction

  function automatic logic [31:0] rand_pos();
    int r;
    r = int'($urandom_range(0, 2999));
    if (r == 0) return 32'hFFFF_FFF0;
    if (r < 3) return FIN_POS + 32'($urandom_range(0, 20));
    return 32'($urandom_range(0, FIN - 1));
  endfunction

  vec_t vt[12];
  int   n;

  initial begin
    vt[0]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
    vt[2]  = mk(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0);
    vt[3]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0);
    vt[6]  = mk(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0);
    vt[8]  = mk(1'b0, 1'b0, 1'b0, 2'd1, 3'd1, 1'b0);
    vt[9]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    vt[11] = mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0);

    do_reset();
    chk("reset_outputs", 64'(dut_vec), 64'd0);

    for (int i = 0; i < 12; i++) begin
      start_req = vt[i].st; restart_req = vt[i].rs; tick_1khz = vt[i].tk;
      cyc();
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(vt[i].e_state));
      chk($sformatf("vec%0d_light", i), 64'(light_stage), 64'(vt[i].e_light));
      chk($sformatf("vec%0d_clr", i), 64'(clear_pulse), 64'(vt[i].e_clr));
    end

    // Countdown then normal finish: p1 at 1234 ms, p2 at 1500 ms.
    do_reset();
    run_countdown(1'b0);
    repeat (1234) cyc();
    chk("p1_time_pre", 64'(p1_time), 64'({12'd1, 10'd234}));
    p1_position = FIN_POS;
    cyc();
    chk("p1_frozen", 64'(p1_time), 64'({12'd1, 10'd234}));
    chk("p1_enable_off", 64'({p1_enable, p2_enable}), 64'(2'b01));
    chk("winner_first", 64'(winner), 64'(WIN_P1));
    repeat (265) cyc();
    chk("end_game_pre", 64'({state, end_game}), 64'({ST_RACE, 1'b0}));
    p2_position = FIN_POS;
    cyc();
    chk("normal_state", 64'({state, end_game}), 64'({ST_FINISHED, 1'b1}));
    chk("normal_p1_time", 64'(p1_time), 64'({12'd1, 10'd234}));
    chk("normal_p2_time", 64'(p2_time), 64'({12'd1, 10'd500}));
    chk("normal_result", 64'({p1_dnf, p2_dnf, winner}), 64'({1'b0, 1'b0, WIN_P1}));

    // Tie: both step 499 -> 500 on the same edge.
    do_restart();
    chk("restart_fin", 64'({state, clear_pulse}), 64'({ST_IDLE, 1'b1}));
    p1_position = 32'd499; p2_position = 32'd499;
    run_countdown(1'b0);
    repeat (100) cyc();
    p1_position = FIN_POS; p2_position = FIN_POS;
    cyc();
    chk("tie_state", 64'(state), 64'(ST_FINISHED));
    chk("tie_winner", 64'(winner), 64'(WIN_TIE));
    chk("tie_times", 64'({p1_time, p2_time}), 64'({12'd0, 10'd100, 12'd0, 10'd100}));

    // Timeout: p1 finishes at 800 ms, p2 never moves.
    do_restart();
    p1_position = '0; p2_position = '0;
    run_countdown(1'b0);
    repeat (800) cyc();
    p1_position = FIN_POS;
    cyc();
    n = 801;
    while (state == ST_RACE && n < 2100) begin
      cyc();
      n++;
    end
    chk("timeout_ms", 64'(n), 64'd2000);
    chk("timeout_state", 64'({state, end_game, p1_enable, p2_enable}), 64'({ST_FINISHED, 3'b100}));
    chk("timeout_dnf", 64'({p1_dnf, p2_dnf, winner}), 64'({1'b0, 1'b1, WIN_P1}));
    chk("timeout_times", 64'({p1_time, p2_time}), 64'({12'd0, 10'd800, 12'd2, 10'd0}));
    repeat (5) cyc();
    chk("finished_hold", 64'({p2_time, light_stage, state}), 64'({12'd2, 10'd0, 3'd5, ST_FINISHED}));

    // Abort at 300 ms, restart beats a simultaneous tick and finish.
    do_restart();
    p1_position = '0;
    run_countdown(1'b0);
    repeat (300) cyc();
    chk("abort_pre", 64'(p1_time), 64'({12'd0, 10'd300}));
    restart_req = 1'b1; p1_position = FIN_POS;
    cyc();
    restart_req = 1'b0;
    chk("abort_state", 64'({state, clear_pulse, light_stage, winner}), 64'({ST_IDLE, 1'b1, 3'd0, WIN_NONE}));
    chk("abort_times", 64'({p1_time, p2_time, p1_enable, p2_enable}), 64'd0);
    cyc();
    chk("abort_pulse_1cyc", 64'(clear_pulse), 64'd0);
    start_req = 1'b1; restart_req = 1'b1;
    cyc();
    start_req = 1'b0; restart_req = 1'b0;
    chk("start_beats_restart", 64'({state, clear_pulse}), 64'({ST_COUNTDOWN, 1'b0}));

    // False start: p1 holds throttle during countdown, then finishes first.
    do_restart();
    p1_position = '0; p2_position = '0;
    run_countdown(1'b1);
    repeat (100) cyc();
    p1_position = FIN_POS;
    cyc();
    repeat (100) cyc();
    p2_position = FIN_POS;
    cyc();
    chk("jump_state", 64'(state), 64'(ST_FINISHED));
`ifdef RACE_FALSE_START_EN
    chk("jump_result", 64'({p1_dnf, p2_dnf, winner}), 64'({1'b1, 1'b0, WIN_P2}));
`else
    chk("jump_result", 64'({p1_dnf, p2_dnf, winner}), 64'({1'b0, 1'b0, WIN_P1}));
`endif

    // Randomized run against the reference model.
    do_reset();
    model_clear();
    for (int c = 0; c < 30000; c++) begin
      reset       = ($urandom_range(0, 7999) != 0);
      start_req   = ($urandom_range(0, 7) == 0);
      restart_req = ($urandom_range(0, 1499) == 0);
      tick_1khz   = ($urandom_range(0, 3) != 0);
      p1_throttle = ($urandom_range(0, 15) == 0);
      p2_throttle = ($urandom_range(0, 15) == 0);
      p1_position = rand_pos();
      p2_position = rand_pos();
      model_step();
      cyc();
      chk($sformatf("rand_cycle%0d", c), 64'(dut_vec), 64'(model_vec()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
